// File: rtl/led_frame_sequencer_pkg.sv
// Shared register map, bit positions and FSM encoding for the frame sequencer.
// No logic: constants, the state type and one small helper only.
// Not applicable: the package carries no flow control.
package led_frame_sequencer_pkg;

  // Slave register word offsets (only wb_adr_i[2:0] is decoded)
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_BASE   = 3'd1;
  localparam logic [2:0] REG_STRIDE = 3'd2;
  localparam logic [2:0] REG_COUNT  = 3'd3;
  localparam logic [2:0] REG_DELAY  = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;

  // CTRL and STATUS bit positions
  localparam int CTRL_EN   = 0;
  localparam int CTRL_LOOP = 1;
  localparam int CTRL_BUSY = 31;
  localparam int STAT_DONE = 8;
  localparam int STAT_ERR  = 9;

  // One-hot sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_WRITE = 3'b010,
    ST_WAIT  = 3'b100
  } seq_state_t;

  // COUNT and DELAY of zero behave as one
  function automatic logic [7:0] at_least_one(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

endpackage

// File: rtl/led_frame_sequencer_regs.sv
// Wishbone slave register file: config, sticky W1C status, enable 0->1 detect.
// Latency: ack and read data one cycle after the request; writes land on the ack edge.
// Backpressure: none, every request is acked on the next cycle.
module led_frame_sequencer_regs
  import led_frame_sequencer_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [2:0]  i_adr,
  input  logic [31:0] i_dat,
  input  logic        i_we,
  input  logic        i_cyc,
  input  logic        i_stb,
  input  logic [3:0]  i_sel,
  output logic [31:0] o_dat,
  output logic        o_ack,
  input  logic        i_busy,
  input  logic [7:0]  i_index,
  input  logic        i_set_done,
  input  logic        i_set_err,
  input  logic        i_clr_en,
  output logic        o_enable,
  output logic        o_loop,
  output logic        o_start,
  output logic [15:0] o_base,
  output logic [15:0] o_stride,
  output logic [7:0]  o_count,
  output logic [7:0]  o_delay
);

  logic        r_ack;
  logic [31:0] r_dat;
  logic        r_enable;
  logic        r_en_d;
  logic        r_loop;
  logic [15:0] r_base;
  logic [15:0] r_stride;
  logic [7:0]  r_count;
  logic [7:0]  r_delay;
  logic        r_done;
  logic        r_err;
  logic [31:0] w_rdata;
  logic        w_req;
  logic        w_wr;
  logic        w_unused_dat;

  assign w_req        = i_cyc & i_stb & ~r_ack;
  assign w_wr         = w_req & i_we & (|i_sel);
  assign w_unused_dat = ^i_dat[31:16];

  // Read mux; unmapped offsets return zero
  always_comb begin
    w_rdata = '0;
    case (i_adr)
      REG_CTRL: begin
        w_rdata[CTRL_EN]   = r_enable;
        w_rdata[CTRL_LOOP] = r_loop;
        w_rdata[CTRL_BUSY] = i_busy;
      end
      REG_BASE:   w_rdata[15:0] = r_base;
      REG_STRIDE: w_rdata[15:0] = r_stride;
      REG_COUNT:  w_rdata[7:0]  = r_count;
      REG_DELAY:  w_rdata[7:0]  = r_delay;
      REG_STATUS: begin
        w_rdata[7:0]       = i_index;
        w_rdata[STAT_DONE] = r_done;
        w_rdata[STAT_ERR]  = r_err;
      end
      default:    w_rdata = '0;
    endcase
  end

  // Register writes: sequencer clears enable before the CPU write so a CPU write wins;
  // hardware set of done/err comes after the W1C so a simultaneous event is not lost.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_enable <= 1'b0;
      r_en_d   <= 1'b0;
      r_loop   <= 1'b0;
      r_base   <= '0;
      r_stride <= '0;
      r_count  <= '0;
      r_delay  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_ack  <= i_cyc & i_stb & ~r_ack;
      r_en_d <= r_enable;
      if (w_req) r_dat <= w_rdata;
      if (i_clr_en) r_enable <= 1'b0;
      if (w_wr) begin
        case (i_adr)
          REG_CTRL: begin
            r_enable <= i_dat[CTRL_EN];
            r_loop   <= i_dat[CTRL_LOOP];
          end
          REG_BASE:   r_base   <= {i_dat[15:1], 1'b0};
          REG_STRIDE: r_stride <= {i_dat[15:1], 1'b0};
          REG_COUNT:  r_count  <= i_dat[7:0];
          REG_DELAY:  r_delay  <= i_dat[7:0];
          REG_STATUS: begin
            if (i_dat[STAT_DONE]) r_done <= 1'b0;
            if (i_dat[STAT_ERR])  r_err  <= 1'b0;
          end
          default: ;
        endcase
      end
      if (i_set_done) r_done <= 1'b1;
      if (i_set_err)  r_err  <= 1'b1;
    end
  end

  assign o_dat    = r_dat;
  assign o_ack    = r_ack;
  assign o_enable = r_enable;
  assign o_loop   = r_loop;
  assign o_start  = r_enable & ~r_en_d;
  assign o_base   = r_base;
  assign o_stride = r_stride;
  assign o_count  = r_count;
  assign o_delay  = r_delay;

endmodule

// File: rtl/led_frame_sequencer.sv
// LED frame sequencer: steps the matrix driver's frame address over a frame list.
// Latency: master cycle starts 1 clk after the enable write / the hold expiring.
// Backpressure: master request held until m_wb_ack_i or ACK_TIMEOUT cycles elapse.
module led_frame_sequencer
  import led_frame_sequencer_pkg::*;
#(
  parameter logic [31:0] TARGET_ADR  = 32'd0,
  parameter int          ACK_TIMEOUT = 255
)
(
  input  logic        wb_clk_i,
  input  logic        wb_reset_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic [31:0] m_wb_adr_o,
  output logic [31:0] m_wb_dat_o,
  output logic [3:0]  m_wb_sel_o,
  output logic        m_wb_we_o,
  output logic        m_wb_cyc_o,
  output logic        m_wb_stb_o,
  input  logic        m_wb_ack_i,
  input  logic        frame_sync,
  output logic        busy
);

  localparam int             TW       = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0]  TMO_LAST = TW'(ACK_TIMEOUT - 1);

  seq_state_t    r_state;
  seq_state_t    w_next;
  logic [7:0]    r_index;
  logic [15:0]   r_frame_addr;
  logic [7:0]    r_hold;
  logic [TW-1:0] r_tmo;

  logic          w_enable, w_loop, w_start;
  logic [15:0]   w_base, w_stride;
  logic [7:0]    w_count, w_delay;
  logic          w_load_first, w_step, w_load_hold;
  logic          w_set_done, w_set_err, w_clr_en;
  logic          w_last;
  logic          w_unused_adr;

  assign w_unused_adr = ^wb_adr_i[31:3];

  led_frame_sequencer_regs u_regs (
    .i_clk      (wb_clk_i),
    .i_rst      (wb_reset_i),
    .i_adr      (wb_adr_i[2:0]),
    .i_dat      (wb_dat_i),
    .i_we       (wb_we_i),
    .i_cyc      (wb_cyc_i),
    .i_stb      (wb_stb_i),
    .i_sel      (wb_sel_i),
    .o_dat      (wb_dat_o),
    .o_ack      (wb_ack_o),
    .i_busy     (busy),
    .i_index    (r_index),
    .i_set_done (w_set_done),
    .i_set_err  (w_set_err),
    .i_clr_en   (w_clr_en),
    .o_enable   (w_enable),
    .o_loop     (w_loop),
    .o_start    (w_start),
    .o_base     (w_base),
    .o_stride   (w_stride),
    .o_count    (w_count),
    .o_delay    (w_delay)
  );

  // Config is sampled live, so a COUNT shrunk below the index ends the list at once
  assign w_last = (r_index >= (at_least_one(w_count) - 8'd1));

  // State register
  always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
    if (wb_reset_i) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  // Next state and one-cycle control strobes for the datapath and register file
  always_comb begin
    w_next       = r_state;
    w_load_first = 1'b0;
    w_step       = 1'b0;
    w_load_hold  = 1'b0;
    w_set_done   = 1'b0;
    w_set_err    = 1'b0;
    w_clr_en     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_next       = ST_WRITE;
          w_load_first = 1'b1;
        end
      end
      ST_WRITE: begin
        if (m_wb_ack_i) begin
          if (w_enable) begin
            w_next      = ST_WAIT;
            w_load_hold = 1'b1;
          end else begin
            w_next = ST_IDLE;
          end
        end else if (r_tmo == TMO_LAST) begin
          w_next    = ST_IDLE;
          w_set_err = 1'b1;
          w_clr_en  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!w_enable) begin
          w_next = ST_IDLE;
        end else if (r_hold == 8'd0) begin
          if (!w_last) begin
            w_next = ST_WRITE;
            w_step = 1'b1;
          end else if (w_loop) begin
            w_next       = ST_WRITE;
            w_load_first = 1'b1;
          end else begin
            w_next     = ST_IDLE;
            w_set_done = 1'b1;
            w_clr_en   = 1'b1;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Frame index/address, hold counter (frame_sync counted only in WAIT) and ack timer
  always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
    if (wb_reset_i) begin
      r_index      <= '0;
      r_frame_addr <= '0;
      r_hold       <= '0;
      r_tmo        <= '0;
    end else begin
      r_tmo <= (r_state == ST_WRITE) ? r_tmo + 1'b1 : '0;
      if (w_load_first) begin
        r_index      <= 8'd0;
        r_frame_addr <= w_base;
      end else if (w_step) begin
        r_index      <= r_index + 8'd1;
        r_frame_addr <= r_frame_addr + w_stride;
      end
      if (w_load_hold)
        r_hold <= at_least_one(w_delay);
      else if (r_state == ST_WAIT && frame_sync && r_hold != 8'd0)
        r_hold <= r_hold - 8'd1;
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign m_wb_cyc_o = (r_state == ST_WRITE);
  assign m_wb_stb_o = (r_state == ST_WRITE);
  assign m_wb_adr_o = TARGET_ADR;
  assign m_wb_dat_o = {16'd0, r_frame_addr};
  assign m_wb_sel_o = 4'hF;
  assign m_wb_we_o  = 1'b1;

endmodule
